// File: rtl/fp_half_pkg.sv
// rtl/fp_half_pkg.sv - shared constants, state encoding and flag layout for the half-precision result packer
package fp_half_pkg;

   localparam int MANT_W = 12;
   localparam int EXP_W  = 6;
   localparam int BIAS   = 15;
   localparam int IEXP_W = 7;
   localparam int FRAC_W = 10;
   localparam int HALF_W = 16;
   localparam int FLAG_W = 4;

   localparam int FLAG_INEXACT   = 3;
   localparam int FLAG_OVERFLOW  = 2;
   localparam int FLAG_UNDERFLOW = 1;
   localparam int FLAG_ZERO      = 0;

   // Biased exponent at which the packed 5-bit field saturates to infinity.
   localparam logic [IEXP_W-1:0] EXP_INF = IEXP_W'(2 * BIAS + 1);

   localparam logic [HALF_W-2:0] HALF_INF_MAG  = 15'h7C00;
   localparam logic [HALF_W-2:0] HALF_ZERO_MAG = 15'h0000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_NORM  = 2'd1,
      ST_ROUND = 2'd2,
      ST_OUT   = 2'd3
   } state_t;

endpackage

// File: rtl/fp_result_packer_if.sv
// rtl/fp_result_packer_if.sv - raw-result input channel and packed binary16 output channel
interface fp_result_packer_if;
   import fp_half_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic              in_sgn;
   logic [MANT_W-1:0] in_mant;
   logic [EXP_W-1:0]  in_exp;
   logic              out_valid;
   logic              out_ready;
   logic [HALF_W-1:0] out_half;
   logic [FLAG_W-1:0] out_flags;

   modport master (
      output in_valid, in_sgn, in_mant, in_exp, out_ready,
      input  in_ready, out_valid, out_half, out_flags
   );

   modport slave (
      input  in_valid, in_sgn, in_mant, in_exp, out_ready,
      output in_ready, out_valid, out_half, out_flags
   );

endinterface

// File: rtl/fp_round_rne.sv
// rtl/fp_round_rne.sv - fraction rounding step; FP_ROUND_RNE_EN selects round-to-nearest-even, else truncate
module fp_round_rne
   import fp_half_pkg::*;
(
   input  logic [FRAC_W-1:0] frac,
   input  logic              guard,
   input  logic              sticky,
   output logic [FRAC_W-1:0] frac_rounded,
   output logic              carry
);

`ifdef FP_ROUND_RNE_EN
   logic inc;

   // Ties go to the even fraction: only round up on a tie when frac is odd.
   assign inc = guard & (sticky | frac[0]);
   assign {carry, frac_rounded} = {1'b0, frac} + {{FRAC_W{1'b0}}, inc};
`else
   logic unused_round;

   assign unused_round = guard | sticky;
   assign frac_rounded = frac;
   assign carry        = 1'b0;
`endif

endmodule

// File: rtl/fp_result_packer.sv
// rtl/fp_result_packer.sv - normalise, round and pack a raw adder result into binary16 with flags
// Rounding mode chosen by FP_ROUND_RNE_EN (see fp_round_rne).
module fp_result_packer
   import fp_half_pkg::*;
(
   input logic               clk,
   input logic               rst,
   fp_result_packer_if.slave bus
);

   state_t state, state_nxt;

   logic              sgn_q;
   logic              guard_q;
   logic              sticky_q;
   logic [MANT_W-1:0] mant_q;
   logic [IEXP_W-1:0] exp_q;

   logic              norm_done;
   logic              is_zero;
   logic              is_denorm;
   logic              round_carry;
   logic [FRAC_W-1:0] frac_rounded;
   logic [IEXP_W-1:0] exp_final;
   logic [HALF_W-1:0] half_nxt;
   logic [FLAG_W-1:0] flags_nxt;
   logic [HALF_W-1:0] out_half_q;
   logic [FLAG_W-1:0] out_flags_q;

   assign is_zero   = (mant_q == '0);
   assign is_denorm = !is_zero && !mant_q[MANT_W-2];
   assign norm_done = is_zero || mant_q[MANT_W-2] || (exp_q <= IEXP_W'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (bus.in_valid) state_nxt = ST_NORM;
         ST_NORM:  if (norm_done) state_nxt = ST_ROUND;
         ST_ROUND: state_nxt = ST_OUT;
         ST_OUT:   if (bus.out_ready) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = (state == ST_IDLE);
      bus.out_valid = (state == ST_OUT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sgn_q       <= 1'b0;
         guard_q     <= 1'b0;
         sticky_q    <= 1'b0;
         mant_q      <= '0;
         exp_q       <= '0;
         out_half_q  <= '0;
         out_flags_q <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  sgn_q    <= bus.in_sgn;
                  sticky_q <= 1'b0;
                  // A carry-out is absorbed at load so NORM only ever shifts left.
                  if (bus.in_mant[MANT_W-1]) begin
                     mant_q  <= {1'b0, bus.in_mant[MANT_W-1:1]};
                     exp_q   <= {1'b0, bus.in_exp} + IEXP_W'(1);
                     guard_q <= bus.in_mant[0];
                  end else begin
                     mant_q  <= bus.in_mant;
                     exp_q   <= {1'b0, bus.in_exp};
                     guard_q <= 1'b0;
                  end
               end
            end
            ST_NORM: begin
               if (!norm_done) begin
                  mant_q <= {mant_q[MANT_W-2:0], 1'b0};
                  exp_q  <= exp_q - IEXP_W'(1);
               end
            end
            ST_ROUND: begin
               out_half_q  <= half_nxt;
               out_flags_q <= flags_nxt;
            end
            default: ;
         endcase
      end
   end

   fp_round_rne u_round (
      .frac         (mant_q[FRAC_W-1:0]),
      .guard        (guard_q),
      .sticky       (sticky_q),
      .frac_rounded (frac_rounded),
      .carry        (round_carry)
   );

   // A rounding carry leaves frac at zero; a denormal that carries becomes the smallest normal.
   assign exp_final = is_denorm ? {{(IEXP_W-1){1'b0}}, round_carry}
                                : exp_q + {{(IEXP_W-1){1'b0}}, round_carry};

   always_comb begin
      half_nxt                 = {sgn_q, exp_final[4:0], frac_rounded};
      flags_nxt                = '0;
      flags_nxt[FLAG_INEXACT]  = guard_q | sticky_q;
      if (is_zero) begin
         half_nxt             = {sgn_q, HALF_ZERO_MAG};
         flags_nxt[FLAG_ZERO] = 1'b1;
      end else if (exp_final >= EXP_INF) begin
         half_nxt                 = {sgn_q, HALF_INF_MAG};
         flags_nxt[FLAG_OVERFLOW] = 1'b1;
      end else if (exp_final[4:0] == 5'd0) begin
         flags_nxt[FLAG_UNDERFLOW] = 1'b1;
      end
   end

   assign bus.out_half  = out_half_q;
   assign bus.out_flags = out_flags_q;

endmodule
